// File: rtl/apu_pkg.sv
// Shared APU definitions: channel index type, channel constants and nibble placement
// within the 16-bit PCM amplitude word.
package apu_pkg;

  typedef logic [1:0] apu_ch_t;

  localparam apu_ch_t APU_CH1 = 2'd0;
  localparam apu_ch_t APU_CH2 = 2'd1;
  localparam apu_ch_t APU_CH3 = 2'd2;
  localparam apu_ch_t APU_CH4 = 2'd3;

  localparam int PCM_NIB_W = 4;

  function automatic int pcm_nib_lsb(apu_ch_t ch);
    return int'(ch) * PCM_NIB_W;
  endfunction

endpackage

// File: rtl/pcm_amp_collector.sv
// Collects one mixer slot per channel into a shadow frame and commits a coherent
// PCM12/PCM34 word. Optional stalled-frame partial commit: PCM_COMMIT_TIMEOUT_EN.
//
// exp_ch | meaning
// -------+--------------------------------------------
// CH1    | idle, waiting for the first slot of a frame
// CH2    | collecting, ch1 captured
// CH3    | collecting, ch1..ch2 captured
// CH4    | collecting, ch1..ch3 captured; next slot commits
module pcm_amp_collector
  import apu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        cgb,
  input  logic        apu_power,
  input  logic [3:0]  ch_on,
  input  logic        sample_valid,
  input  logic [1:0]  sample_ch,
  input  logic [3:0]  sample_amp,
  output logic [15:0] pcm_amp,
  output logic        frame_commit,
  output logic        seq_error
);

  apu_ch_t     exp_ch, exp_ch_nxt;
  logic [11:0] shadow, shadow_nxt;
  logic [15:0] pcm_amp_nxt;
  logic        frame_commit_nxt;
  logic        seq_error_nxt;
  logic [3:0]  slot_nib;
  logic [15:0] ch_on_mask;
  logic        powered;

  assign powered    = cgb & apu_power;
  assign slot_nib   = ch_on[sample_ch] ? sample_amp : 4'h0;
  assign ch_on_mask = {{4{ch_on[3]}}, {4{ch_on[2]}}, {4{ch_on[1]}}, {4{ch_on[0]}}};

`ifdef PCM_COMMIT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_nxt;
  end
`else
  // Without the timeout a stalled frame simply waits; the limit has no effect.
  if (TIMEOUT_CYCLES < 1) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_ch       <= APU_CH1;
      shadow       <= '0;
      pcm_amp      <= '0;
      frame_commit <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      exp_ch       <= exp_ch_nxt;
      shadow       <= shadow_nxt;
      pcm_amp      <= pcm_amp_nxt;
      frame_commit <= frame_commit_nxt;
      seq_error    <= seq_error_nxt;
    end
  end

  always_comb begin
    exp_ch_nxt       = exp_ch;
    shadow_nxt       = shadow;
    pcm_amp_nxt      = pcm_amp;
    frame_commit_nxt = 1'b0;
    seq_error_nxt    = seq_error;
`ifdef PCM_COMMIT_TIMEOUT_EN
    tmo_cnt_nxt      = tmo_cnt;
`endif
    if (cpu_en) begin
      if (!powered) begin
        exp_ch_nxt  = APU_CH1;
        shadow_nxt  = '0;
        pcm_amp_nxt = '0;
`ifdef PCM_COMMIT_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
      end else begin
        if (sample_valid && (apu_ch_t'(sample_ch) == exp_ch)) begin
`ifdef PCM_COMMIT_TIMEOUT_EN
          tmo_cnt_nxt = '0;
`endif
          if (exp_ch == APU_CH4) begin
            pcm_amp_nxt      = {slot_nib, shadow};
            frame_commit_nxt = 1'b1;
            shadow_nxt       = '0;
            exp_ch_nxt       = APU_CH1;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (exp_ch == apu_ch_t'(i))
                shadow_nxt[pcm_nib_lsb(apu_ch_t'(i)) +: PCM_NIB_W] = slot_nib;
            end
            exp_ch_nxt = exp_ch + 2'd1;
          end
        end else if (sample_valid) begin
          // Resync: a stray ch1 slot is taken as the start of a fresh frame.
          seq_error_nxt = 1'b1;
          shadow_nxt    = '0;
`ifdef PCM_COMMIT_TIMEOUT_EN
          tmo_cnt_nxt   = '0;
`endif
          if (apu_ch_t'(sample_ch) == APU_CH1) begin
            shadow_nxt[PCM_NIB_W-1:0] = slot_nib;
            exp_ch_nxt                = APU_CH2;
          end else begin
            exp_ch_nxt = APU_CH1;
          end
        end
`ifdef PCM_COMMIT_TIMEOUT_EN
        else if (exp_ch != APU_CH1) begin
          if (tmo_cnt == TMO_LAST) begin
            for (int i = 0; i < 3; i++) begin
              if (apu_ch_t'(i) < exp_ch)
                pcm_amp_nxt[pcm_nib_lsb(apu_ch_t'(i)) +: PCM_NIB_W] =
                  shadow[pcm_nib_lsb(apu_ch_t'(i)) +: PCM_NIB_W];
            end
            frame_commit_nxt = 1'b1;
            shadow_nxt       = '0;
            exp_ch_nxt       = APU_CH1;
            tmo_cnt_nxt      = '0;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
`endif
        // Disabled channels read zero even over a commit on the same edge.
        pcm_amp_nxt = pcm_amp_nxt & ch_on_mask;
      end
    end
  end

endmodule
